// File: rtl/filt_fir_mc_pkg.sv
// Shared types and helpers for the multi-channel FIR filter.
// Output saturation is selected with FILT_FIR_MC_SAT_EN.
package filt_fir_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_t;

  function automatic int acc_width(int iw, int cw, int l);
    return iw + cw + $clog2(l);
  endfunction

  function automatic int ch_width(int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

  // Caller keeps the low w bits; with sat=0 that is a plain wrap.
  function automatic logic signed [63:0] sat_wrap(
    logic signed [63:0] v,
    int                 w,
    logic               sat
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (!sat) return v;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/filt_fir_mc_mac.sv
// Shared multiply-accumulate plus output shift and sat/wrap register.
// FILT_FIR_MC_SAT_EN selects clipping instead of two's-complement wrap.
module filt_fir_mc_mac
  import filt_fir_mc_pkg::*;
#(
  parameter int gp_inp_width    = 16,
  parameter int gp_coeff_width  = 16,
  parameter int gp_coeff_length = 16,
  parameter int gp_oup_shift    = 0,
  parameter int gp_oup_width    = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_ena,
  input  logic                             i_clr,
  input  logic                             i_mac,
  input  logic                             i_last,
  input  logic signed [gp_coeff_width-1:0] i_coeff,
  input  logic signed [gp_inp_width-1:0]   i_sample,
  output logic signed [gp_oup_width-1:0]   o_data
);

  localparam int AW = acc_width(gp_inp_width, gp_coeff_width,
                                gp_coeff_length);
  localparam int PW = gp_inp_width + gp_coeff_width;

`ifdef FILT_FIR_MC_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic signed [PW-1:0] prod;
  logic signed [63:0]   res;
  logic signed [63:0]   fmt;
  logic                 unused_hi;

  always_comb begin
    prod  = PW'(i_coeff) * PW'(i_sample);
    acc_d = acc_q + AW'(prod);
    res   = 64'(acc_d) >>> gp_oup_shift;
    fmt   = sat_wrap(res, gp_oup_width, SAT);
  end

  assign unused_hi = ^fmt[63:gp_oup_width];

  // The result is captured together with the final product so it is
  // ready in the OUT cycle and held until the next sample completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q  <= '0;
      o_data <= '0;
    end else if (i_ena) begin
      if (i_clr) begin
        acc_q <= '0;
      end else if (i_mac) begin
        acc_q <= acc_d;
        if (i_last) o_data <= fmt[gp_oup_width-1:0];
      end
    end
  end

endmodule

// File: rtl/filt_fir_mc.sv
// Multi-channel FIR: one time-shared MAC, per-channel delay lines.
// Define FILT_FIR_MC_SAT_EN to clip the output instead of wrapping.
module filt_fir_mc
  import filt_fir_mc_pkg::*;
#(
  parameter int gp_inp_width    = 16,
  parameter int gp_coeff_width  = 16,
  parameter int gp_coeff_length = 16,
  parameter int gp_nr_ch        = 4,
  parameter int gp_oup_shift    = 0,
  parameter int gp_oup_width    = 16
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_ena,
  input  logic                                    i_valid,
  output logic                                    o_ready,
  input  logic [ch_width(gp_nr_ch)-1:0]           i_ch,
  input  logic signed [gp_inp_width-1:0]          i_data,
  input  logic                                    i_coeff_we,
  input  logic [$clog2(gp_coeff_length)-1:0]      i_coeff_addr,
  input  logic signed [gp_coeff_width-1:0]        i_coeff_data,
  output logic                                    o_valid,
  output logic [ch_width(gp_nr_ch)-1:0]           o_ch,
  output logic signed [gp_oup_width-1:0]          o_data
);

  localparam int L  = gp_coeff_length;
  localparam int C  = gp_nr_ch;
  localparam int CW = ch_width(C);
  localparam int KW = $clog2(L);

  state_t st_q, st_d;

  logic [KW-1:0] k_q;
  logic [KW-1:0] wp;
  logic [KW-1:0] idx;
  logic [CW-1:0] ch_q;
  logic [KW-1:0] wptr_q [C];

  logic signed [gp_inp_width-1:0]   x_q [C][L];
  logic signed [gp_coeff_width-1:0] c_q [L];

  logic accept;
  logic ch_ok;
  logic take;
  logic last;
  logic cw_ok;

  // Ready is gated by the enable so a handshake never goes unregistered.
  assign o_ready = (st_q == ST_IDLE) & i_ena & ~i_rst;
  assign o_valid = (st_q == ST_OUT) & i_ena & ~i_rst;
  assign accept  = o_ready & i_valid;
  assign ch_ok   = 32'(i_ch) < C;
  assign take    = accept & ch_ok;
  assign last    = k_q == KW'(L - 1);
  assign cw_ok   = i_coeff_we & (st_q == ST_IDLE)
                 & (32'(i_coeff_addr) < L);

  always_comb begin
    wp = wptr_q[ch_q];
    if (wp >= k_q) idx = wp - k_q;
    else           idx = KW'(32'(wp) + L - 32'(k_q));
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: if (take) st_d = ST_MAC;
      ST_MAC:  if (last) st_d = ST_OUT;
      ST_OUT:  st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q <= ST_IDLE;
      k_q  <= '0;
      ch_q <= '0;
      o_ch <= '0;
      for (int i = 0; i < C; i++) begin
        wptr_q[i] <= '0;
        for (int j = 0; j < L; j++) x_q[i][j] <= '0;
      end
      for (int j = 0; j < L; j++) c_q[j] <= '0;
    end else if (i_ena) begin
      st_q <= st_d;
      if (cw_ok) c_q[i_coeff_addr] <= i_coeff_data;
      if (take) begin
        x_q[i_ch][wptr_q[i_ch]] <= i_data;
        ch_q <= i_ch;
        k_q  <= '0;
      end
      if (st_q == ST_MAC) begin
        k_q <= k_q + 1'b1;
        if (last) o_ch <= ch_q;
      end
      if (st_q == ST_OUT) begin
        wptr_q[ch_q] <= (wptr_q[ch_q] == KW'(L - 1)) ? '0
                      : wptr_q[ch_q] + 1'b1;
      end
    end
  end

  filt_fir_mc_mac #(
    .gp_inp_width   (gp_inp_width),
    .gp_coeff_width (gp_coeff_width),
    .gp_coeff_length(gp_coeff_length),
    .gp_oup_shift   (gp_oup_shift),
    .gp_oup_width   (gp_oup_width)
  ) u_mac (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_ena   (i_ena),
    .i_clr   (take),
    .i_mac   (st_q == ST_MAC),
    .i_last  (last),
    .i_coeff (c_q[k_q]),
    .i_sample(x_q[ch_q][idx]),
    .o_data  (o_data)
  );

endmodule

// File: tb/tb_filt_fir_mc.sv
// Directed self-checking bench for filt_fir_mc (L=16, C=4).
// Expected values follow FILT_FIR_MC_SAT_EN when it is defined.
module tb_filt_fir_mc;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_ena = 1'b1;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [1:0]        i_ch = '0;
  logic signed [15:0] i_data = '0;
  logic              i_coeff_we = 1'b0;
  logic [3:0]        i_coeff_addr = '0;
  logic signed [15:0] i_coeff_data = '0;
  logic              o_valid;
  logic [1:0]        o_ch;
  logic signed [15:0] o_data;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  filt_fir_mc dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ena       (i_ena),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_ch        (i_ch),
    .i_data      (i_data),
    .i_coeff_we  (i_coeff_we),
    .i_coeff_addr(i_coeff_addr),
    .i_coeff_data(i_coeff_data),
    .o_valid     (o_valid),
    .o_ch        (o_ch),
    .o_data      (o_data)
  );

  task automatic do_reset;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // mode 0: c[k]=k+1, mode 1: every tap = val
  task automatic load_coeffs(input int mode, input int val);
    for (int k = 0; k < 16; k++) begin
      @(negedge i_clk);
      i_coeff_we   = 1'b1;
      i_coeff_addr = 4'(k);
      i_coeff_data = (mode == 0) ? 16'(k + 1) : 16'(val);
    end
    @(negedge i_clk);
    i_coeff_we = 1'b0;
  endtask

  // Offers one sample in cycle 0 and watches up to 40 cycles for o_valid.
  task automatic run_sample(
    input  logic [1:0]        ch,
    input  logic signed [15:0] d,
    input  int                ena_lo_at,
    input  int                rst_at,
    input  int                cw_at,
    input  logic [3:0]        ca,
    input  logic signed [15:0] cd,
    output logic              got,
    output logic [1:0]        gch,
    output logic signed [15:0] gd,
    output int                lat
  );
    got = 1'b0;
    gch = '0;
    gd  = '0;
    lat = -1;
    @(negedge i_clk);
    i_valid      = 1'b1;
    i_ch         = ch;
    i_data       = d;
    i_coeff_we   = (cw_at == 0);
    i_coeff_addr = ca;
    i_coeff_data = cd;
    for (int j = 0; j < 40; j++) begin
      if (j > 0) begin
        @(negedge i_clk);
        i_valid    = 1'b0;
        i_ena      = !(ena_lo_at > 0 && j >= ena_lo_at
                       && j < ena_lo_at + 3);
        i_rst      = (j == rst_at);
        i_coeff_we = (cw_at > 0 && j == cw_at);
      end
      #1;
      if (o_valid) begin
        got = 1'b1;
        gch = o_ch;
        gd  = o_data;
        lat = j;
        break;
      end
    end
    i_valid    = 1'b0;
    i_ena      = 1'b1;
    i_rst      = 1'b0;
    i_coeff_we = 1'b0;
  endtask

  task automatic test_reset;
    logic got;
    logic [1:0] gch;
    logic signed [15:0] gd;
    int lat;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    #1;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", o_ready);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", o_valid);
    end
    checks++;
    if (o_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_ch: got %0d want 0", o_ch);
    end
    checks++;
    if (o_data !== 16'sd0) begin
      errors++;
      $display("FAIL reset_data: got %0d want 0", o_data);
    end
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b want 1", o_ready);
    end
    run_sample(2'd0, 16'sd5, 0, -1, -1, 4'd0, 16'sd0,
               got, gch, gd, lat);
    checks++;
    if (!got || gd !== 16'sd0 || lat != 17) begin
      errors++;
      $display("FAIL zero_coeff: got v=%b d=%0d lat=%0d want v=1 d=0 lat=17",
               got, gd, lat);
    end
  endtask

  task automatic test_impulse;
    logic got;
    logic [1:0] gch;
    logic signed [15:0] gd;
    int lat;
    do_reset();
    load_coeffs(0, 0);
    for (int n = 0; n < 16; n++) begin
      run_sample(2'd0, (n == 0) ? 16'sd1 : 16'sd0, 0, -1, -1, 4'd0,
                 16'sd0, got, gch, gd, lat);
      checks++;
      if (!got || gch !== 2'd0 || gd !== 16'(n + 1) || lat != 17) begin
        errors++;
        $display("FAIL impulse n=%0d: got v=%b ch=%0d d=%0d lat=%0d want ch=0 d=%0d lat=17",
                 n, got, gch, gd, lat, n + 1);
      end
    end
  endtask

  task automatic test_interleave;
    logic got;
    logic [1:0] gch;
    logic signed [15:0] gd;
    int lat;
    do_reset();
    load_coeffs(0, 0);
    for (int p = 0; p < 4; p++) begin
      run_sample(2'd1, (p == 0) ? 16'sd100 : 16'sd0, 0, -1, -1, 4'd0,
                 16'sd0, got, gch, gd, lat);
      checks++;
      if (!got || gch !== 2'd1 || gd !== 16'(100 * (p + 1))) begin
        errors++;
        $display("FAIL interleave ch1 p=%0d: got v=%b ch=%0d d=%0d want ch=1 d=%0d",
                 p, got, gch, gd, 100 * (p + 1));
      end
      run_sample(2'd0, 16'sd0, 0, -1, -1, 4'd0, 16'sd0,
                 got, gch, gd, lat);
      checks++;
      if (!got || gch !== 2'd0 || gd !== 16'sd0) begin
        errors++;
        $display("FAIL interleave ch0 p=%0d: got v=%b ch=%0d d=%0d want ch=0 d=0",
                 p, got, gch, gd);
      end
    end
  endtask

  task automatic test_wrap;
    logic got;
    logic [1:0] gch;
    logic signed [15:0] gd;
    int lat;
    int exp;
    do_reset();
    load_coeffs(1, 32767);
    for (int n = 0; n < 16; n++) begin
      run_sample(2'd2, 16'sd32767, 0, -1, -1, 4'd0, 16'sd0,
                 got, gch, gd, lat);
`ifdef FILT_FIR_MC_SAT_EN
      exp = 32767;
`else
      exp = n + 1;
`endif
      checks++;
      if (!got || gch !== 2'd2 || gd !== 16'(exp)) begin
        errors++;
        $display("FAIL wrap n=%0d: got v=%b ch=%0d d=%0d want ch=2 d=%0d",
                 n, got, gch, gd, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int low;
    int nv;
    logic idle;
    low = 0;
    nv  = 0;
    do_reset();
    load_coeffs(0, 0);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_ch    = 2'd3;
    i_data  = 16'sd0;
    for (int j = 0; j < 40; j++) begin
      #1;
      if (o_ready) acc.push_back(j);
      else if (acc.size() == 1) low++;
      if (o_valid) nv++;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    checks++;
    if (acc.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d acceptances want 3", acc.size());
    end else begin
      checks++;
      if (acc[1] - acc[0] != 18 || acc[2] - acc[1] != 18) begin
        errors++;
        $display("FAIL b2b_gap: got %0d,%0d want 18,18",
                 acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    checks++;
    if (low != 17) begin
      errors++;
      $display("FAIL b2b_ready_low: got %0d cycles want 17", low);
    end
    checks++;
    if (nv != 2) begin
      errors++;
      $display("FAIL b2b_valids: got %0d want 2", nv);
    end
    idle = 1'b0;
    for (int j = 0; j < 30; j++) begin
      #1;
      if (o_ready) begin
        idle = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL b2b_drain: got ready=0 want 1 within 30 cycles");
    end
  endtask

  task automatic test_reset_mid;
    logic got;
    logic [1:0] gch;
    logic signed [15:0] gd;
    int lat;
    do_reset();
    load_coeffs(0, 0);
    run_sample(2'd0, 16'sd7, 0, 5, -1, 4'd0, 16'sd0,
               got, gch, gd, lat);
    checks++;
    if (got) begin
      errors++;
      $display("FAIL rst_mid_valid: got o_valid at %0d want none", lat);
    end
    checks++;
    if (o_data !== 16'sd0) begin
      errors++;
      $display("FAIL rst_mid_data: got %0d want 0", o_data);
    end
    load_coeffs(0, 0);
    run_sample(2'd0, 16'sd1, 0, -1, -1, 4'd0, 16'sd0,
               got, gch, gd, lat);
    checks++;
    if (!got || gch !== 2'd0 || gd !== 16'sd1) begin
      errors++;
      $display("FAIL rst_mid_next: got v=%b ch=%0d d=%0d want ch=0 d=1",
               got, gch, gd);
    end
    run_sample(2'd0, 16'sd0, 0, -1, -1, 4'd0, 16'sd0,
               got, gch, gd, lat);
    checks++;
    if (!got || gd !== 16'sd2) begin
      errors++;
      $display("FAIL rst_mid_hist: got v=%b d=%0d want d=2", got, gd);
    end
  endtask

  task automatic test_enable;
    logic got;
    logic [1:0] gch;
    logic signed [15:0] gd;
    int lat;
    do_reset();
    load_coeffs(0, 0);
    run_sample(2'd0, 16'sd1, 5, -1, -1, 4'd0, 16'sd0,
               got, gch, gd, lat);
    checks++;
    if (!got || gd !== 16'sd1 || lat != 20) begin
      errors++;
      $display("FAIL ena_stall: got v=%b d=%0d lat=%0d want d=1 lat=20",
               got, gd, lat);
    end
  endtask

  task automatic test_coeff_rules;
    logic got;
    logic [1:0] gch;
    logic signed [15:0] gd;
    int lat;
    do_reset();
    load_coeffs(0, 0);
    run_sample(2'd0, 16'sd1, 0, -1, 3, 4'd3, 16'sd99,
               got, gch, gd, lat);
    checks++;
    if (!got || gd !== 16'sd1) begin
      errors++;
      $display("FAIL cw_busy_first: got v=%b d=%0d want d=1", got, gd);
    end
    for (int n = 1; n < 4; n++) begin
      run_sample(2'd0, 16'sd0, 0, -1, -1, 4'd0, 16'sd0,
                 got, gch, gd, lat);
      checks++;
      if (!got || gd !== 16'(n + 1)) begin
        errors++;
        $display("FAIL cw_busy n=%0d: got v=%b d=%0d want d=%0d",
                 n, got, gd, n + 1);
      end
    end
    run_sample(2'd1, 16'sd1, 0, -1, 0, 4'd0, 16'sd50,
               got, gch, gd, lat);
    checks++;
    if (!got || gch !== 2'd1 || gd !== 16'sd50) begin
      errors++;
      $display("FAIL cw_same_cycle: got v=%b ch=%0d d=%0d want ch=1 d=50",
               got, gch, gd);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_impulse();
    test_interleave();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_enable();
    test_coeff_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
